// File: rtl/puzzle_pkg.sv
// Shared definitions for the 8-puzzle board register file: board geometry,
// default sweep constants, the controller state type and a tile-index check.
package puzzle_pkg;

   localparam int TILE_W  = 4;
   localparam int N_TILES = 9;
   localparam int BOARD_W = TILE_W * N_TILES;

   // Start position (blank in tile 5) and solved position (blank in tile 8).
   localparam logic [BOARD_W-1:0] DEF_INIT_BOARD = 36'h1234_5078_6;
   localparam logic [BOARD_W-1:0] DEF_GOAL_BOARD = 36'h1234_5678_0;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } rf_state_t;

   // A tile index names a real tile only when it is below the tile count.
   function automatic logic tile_idx_valid(input logic [3:0] idx, input int n_tiles);
      return (int'(idx) < n_tiles);
   endfunction

endpackage

// File: rtl/puzzle_board_regfile_if.sv
// Request/response bundle between the solver control FSM (master) and the
// board register file (slave).
interface puzzle_board_regfile_if #(
   parameter int DATA_W = 36,
   parameter int ADDR_W = 4,
   parameter int NRD    = 2
);

   logic [NRD*ADDR_W-1:0] src;
   logic [NRD*DATA_W-1:0] rdata;
   logic                  we;
   logic [ADDR_W-1:0]     dst;
   logic [DATA_W-1:0]     wdata;
   logic                  swap_en;
   logic [3:0]            swap_a;
   logic [3:0]            swap_b;
   logic                  ready;
   logic                  err;

   modport master (
      output src, we, dst, wdata, swap_en, swap_a, swap_b,
      input  rdata, ready, err
   );

   modport slave (
      input  src, we, dst, wdata, swap_en, swap_a, swap_b,
      output rdata, ready, err
   );

endinterface

// File: rtl/rf_tile_swap.sv
// Combinational tile exchange: returns the board with tiles a and b swapped.
// Tile 0 is the most significant nibble. If either index is not a real tile
// the board passes through unchanged.
module rf_tile_swap #(
   parameter int TILE_W  = puzzle_pkg::TILE_W,
   parameter int N_TILES = puzzle_pkg::N_TILES,
   parameter int DATA_W  = TILE_W * N_TILES
) (
   input  logic [DATA_W-1:0] board,
   input  logic [3:0]        a,
   input  logic [3:0]        b,
   output logic [DATA_W-1:0] swapped
);
   import puzzle_pkg::*;

   logic [TILE_W-1:0] tile_a;
   logic [TILE_W-1:0] tile_b;

   // Pick out both tiles by scanning, then write them back crosswise.
   always_comb begin
      tile_a  = '0;
      tile_b  = '0;
      swapped = board;
      for (int i = 0; i < N_TILES; i++) begin
         if (int'(a) == i) tile_a = board[DATA_W-1-i*TILE_W -: TILE_W];
         if (int'(b) == i) tile_b = board[DATA_W-1-i*TILE_W -: TILE_W];
      end
      if (tile_idx_valid(a, N_TILES) && tile_idx_valid(b, N_TILES)) begin
         for (int i = 0; i < N_TILES; i++) begin
            if (int'(a) == i) swapped[DATA_W-1-i*TILE_W -: TILE_W] = tile_b;
            if (int'(b) == i) swapped[DATA_W-1-i*TILE_W -: TILE_W] = tile_a;
         end
      end
   end

endmodule

// File: rtl/puzzle_board_regfile.sv
// Multi-read-port register file of 8-puzzle boards. After reset it sweeps
// every entry (entry 0 = start board, entry 1 = goal board, rest = 0) and then
// serves combinational reads, writes, and in-place blank-move tile swaps.
// Rejected operations raise a one-cycle registered err pulse.
// Build option: define RF_BYPASS_EN to make a read of the entry being
// written/swapped in the same cycle return the new value (write-through).
module puzzle_board_regfile #(
   parameter int TILE_W  = puzzle_pkg::TILE_W,
   parameter int N_TILES = puzzle_pkg::N_TILES,
   parameter int DATA_W  = TILE_W * N_TILES,
   parameter int DEPTH   = 16,
   parameter int ADDR_W  = $clog2(DEPTH),
   parameter int NRD     = 2,
   parameter logic [DATA_W-1:0] INIT_BOARD = puzzle_pkg::DEF_INIT_BOARD,
   parameter logic [DATA_W-1:0] GOAL_BOARD = puzzle_pkg::DEF_GOAL_BOARD
) (
   input  logic                    clk,
   input  logic                    rst_n,
   puzzle_board_regfile_if.slave   bus
);
   import puzzle_pkg::*;

   localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

   rf_state_t         state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];

   logic              wr_en;
   logic [ADDR_W-1:0] wr_idx;
   logic [DATA_W-1:0] wr_val;
   logic              dst_ok;
   logic              a_ok;
   logic              b_ok;
   logic [DATA_W-1:0] swap_src;
   logic [DATA_W-1:0] swap_res;
   logic [ADDR_W-1:0] src_k;
   logic [NRD*DATA_W-1:0] rdata_c;

   assign dst_ok   = ({1'b0, bus.dst} < DEPTH_X);
   assign a_ok     = tile_idx_valid(bus.swap_a, N_TILES);
   assign b_ok     = tile_idx_valid(bus.swap_b, N_TILES);
   assign swap_src = dst_ok ? mem_q[bus.dst] : '0;

   rf_tile_swap #(
      .TILE_W  (TILE_W),
      .N_TILES (N_TILES),
      .DATA_W  (DATA_W)
   ) u_swap (
      .board   (swap_src),
      .a       (bus.swap_a),
      .b       (bus.swap_b),
      .swapped (swap_res)
   );

   // Controller: init sweep, request arbitration, single write-port select, err.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      err_d   = 1'b0;
      wr_en   = 1'b0;
      wr_idx  = ptr_q;
      wr_val  = '0;
      if (!rst_n) begin
         state_d = INIT;
         ptr_d   = '0;
      end else begin
         case (state_q)
            INIT: begin
               wr_en  = 1'b1;
               wr_idx = ptr_q;
               if (ptr_q == '0)
                  wr_val = INIT_BOARD;
               else if (ptr_q == ADDR_W'(1))
                  wr_val = GOAL_BOARD;
               else
                  wr_val = '0;
               ptr_d = ptr_q + 1'b1;
               if (ptr_q == LAST_PTR) begin
                  state_d = RUN;
                  ptr_d   = '0;
               end
               // The bus is not serviced until the sweep is done.
               err_d = bus.we | bus.swap_en;
            end
            RUN: begin
               wr_idx = bus.dst;
               if (bus.we) begin
                  // A write wins over a simultaneous swap; the swap is reported.
                  wr_en  = dst_ok;
                  wr_val = bus.wdata;
                  err_d  = bus.swap_en | ~dst_ok;
               end else if (bus.swap_en) begin
                  if (a_ok && b_ok && dst_ok) begin
                     wr_en  = (bus.swap_a != bus.swap_b);
                     wr_val = swap_res;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            default: begin
               state_d = INIT;
               ptr_d   = '0;
            end
         endcase
      end
   end

   // Next memory contents: the current array with the selected entry replaced.
   always_comb begin
      mem_d = mem_q;
      if (wr_en) mem_d[wr_idx] = wr_val;
   end

   // Read ports: zero during the sweep and for out-of-range addresses.
   always_comb begin
      rdata_c = '0;
      src_k   = '0;
      if (state_q == RUN) begin
         for (int k = 0; k < NRD; k++) begin
            src_k = bus.src[k*ADDR_W +: ADDR_W];
            if ({1'b0, src_k} < DEPTH_X) begin
`ifdef RF_BYPASS_EN
               rdata_c[k*DATA_W +: DATA_W] = mem_d[src_k];
`else
               rdata_c[k*DATA_W +: DATA_W] = mem_q[src_k];
`endif
            end
         end
      end
   end

   assign bus.rdata = rdata_c;
   assign bus.ready = (state_q == RUN);
   assign bus.err   = err_q;

   // State, pointer, error flag and storage all load their next values here.
   always_ff @(posedge clk) begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      mem_q   <= mem_d;
   end

endmodule

// File: tb/tb_puzzle_board_regfile.sv
// Directed bench for puzzle_board_regfile. The driver issues one request per
// cycle and queues the expected outputs tagged with the cycle they belong to;
// a monitor on the falling edge pops and compares them.
module tb_puzzle_board_regfile;

`ifdef RF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   localparam logic [35:0] B_INIT = 36'h123450786;
   localparam logic [35:0] B_GOAL = 36'h123456780;

   logic clk;
   logic rst_n;

   puzzle_board_regfile_if #(.DATA_W(36), .ADDR_W(4), .NRD(2)) bus ();

   puzzle_board_regfile dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      int          kind;   // 0 rdata port0, 1 rdata port1, 2 ready, 3 err
      logic [35:0] val;
      string       name;
   } exp_t;

   exp_t        sbq[$];
   int          cyc;
   int          n_tests;
   int          n_fail;
   logic [35:0] model [16];

   function automatic logic [35:0] observe(input int kind);
      case (kind)
         0:       return bus.rdata[35:0];
         1:       return bus.rdata[71:36];
         2:       return {35'd0, bus.ready};
         default: return {35'd0, bus.err};
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic push(input int at, input int kind, input logic [35:0] v, input string nm);
      exp_t e;
      e.cyc  = at;
      e.kind = kind;
      e.val  = v;
      e.name = nm;
      sbq.push_back(e);
   endtask

   task automatic idle();
      bus.we      = 1'b0;
      bus.swap_en = 1'b0;
      bus.dst     = '0;
      bus.wdata   = '0;
      bus.swap_a  = '0;
      bus.swap_b  = '0;
      bus.src     = '0;
   endtask

   task automatic model_init();
      for (int i = 0; i < 16; i++) model[i] = 36'h0;
      model[0] = B_INIT;
      model[1] = B_GOAL;
   endtask

   task automatic read_all(input string tag);
      for (int i = 0; i < 16; i++) begin
         step();
         idle();
         bus.src = {4'(15 - i), 4'(i)};
         push(cyc, 0, model[i],      $sformatf("%s_p0_e%0d", tag, i));
         push(cyc, 1, model[15 - i], $sformatf("%s_p1_e%0d", tag, 15 - i));
         push(cyc, 3, 36'd0,         $sformatf("%s_err_quiet%0d", tag, i));
      end
   endtask

   // Monitor: compare every expectation due in the current cycle.
   always @(negedge clk) begin
      int          i;
      logic [35:0] got;
      i = 0;
      while (i < sbq.size()) begin
         if (sbq[i].cyc == cyc) begin
            got = observe(sbq[i].kind);
            n_tests++;
            if (got !== sbq[i].val) begin
               n_fail++;
               $display("FAIL %s: got %h, expected %h (cycle %0d)",
                        sbq[i].name, got, sbq[i].val, cyc);
            end
            sbq.delete(i);
         end else if (sbq[i].cyc < cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: never sampled, due at cycle %0d", sbq[i].name, sbq[i].cyc);
            sbq.delete(i);
         end else begin
            i++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d expectations pending", sbq.size());
      $fatal(1, "watchdog");
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      cyc     = 0;
      rst_n   = 1'b0;
      idle();
      model_init();

      // Held in reset: not ready, no error, reads return zero.
      repeat (3) begin
         step();
         push(cyc, 2, 36'd0, "rst_ready");
         push(cyc, 3, 36'd0, "rst_err");
         push(cyc, 0, 36'd0, "rst_rdata0");
      end

      // Release: ready stays low for exactly 16 cycles; a write mid-sweep is refused.
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (i > 0) step();
         idle();
         if (i == 3) begin
            bus.we    = 1'b1;
            bus.dst   = 4'd2;
            bus.wdata = 36'hFFFFFFFFF;
         end
         push(cyc, 2, 36'd0, $sformatf("sweep_ready%0d", i));
         push(cyc, 0, 36'd0, $sformatf("sweep_rdata%0d", i));
         push(cyc, 3, (i == 4) ? 36'd1 : 36'd0, $sformatf("sweep_err%0d", i));
      end
      step();
      idle();
      push(cyc, 2, 36'd1, "run_ready");
      push(cyc, 3, 36'd0, "run_err_clear");
      read_all("init");

      // Write with same-cycle read of the target.
      step();
      idle();
      bus.we    = 1'b1;
      bus.dst   = 4'd5;
      bus.wdata = 36'h0ABCDEF01;
      bus.src   = {4'd4, 4'd5};
      push(cyc, 0, BYP ? 36'h0ABCDEF01 : 36'h0, "wr_same_cycle");
      push(cyc, 1, 36'h0, "wr_other_port");
      push(cyc + 1, 3, 36'd0, "wr_no_err");
      step();
      idle();
      bus.src = {4'd0, 4'd5};
      push(cyc, 0, 36'h0ABCDEF01, "wr_next_cycle");
      model[5] = 36'h0ABCDEF01;

      // Blank move on entry 0: tiles 5 and 8.
      step();
      idle();
      bus.swap_en = 1'b1;
      bus.dst     = 4'd0;
      bus.swap_a  = 4'd5;
      bus.swap_b  = 4'd8;
      bus.src     = {4'd0, 4'd0};
      push(cyc, 0, BYP ? 36'h123456780 : 36'h123450786, "swap_same_cycle");
      push(cyc + 1, 3, 36'd0, "swap_no_err");
      step();
      idle();
      push(cyc, 0, 36'h123456780, "swap_result");
      model[0] = 36'h123456780;

      // Swap of a tile with itself leaves entry 1 alone without an error.
      step();
      idle();
      bus.swap_en = 1'b1;
      bus.dst     = 4'd1;
      bus.swap_a  = 4'd3;
      bus.swap_b  = 4'd3;
      bus.src     = {4'd0, 4'd1};
      push(cyc, 0, 36'h123456780, "swap_same_idx");
      push(cyc + 1, 3, 36'd0, "swap_same_idx_err");

      // Swap of the outermost tiles 0 and 8 of entry 1.
      step();
      idle();
      bus.swap_en = 1'b1;
      bus.dst     = 4'd1;
      bus.swap_a  = 4'd0;
      bus.swap_b  = 4'd8;
      bus.src     = {4'd0, 4'd1};
      push(cyc, 0, BYP ? 36'h023456781 : 36'h123456780, "swap_ends_same_cycle");
      push(cyc + 1, 3, 36'd0, "swap_ends_err");
      model[1] = 36'h023456781;

      // Write and swap together: write wins, err pulses for a single cycle.
      step();
      idle();
      bus.we      = 1'b1;
      bus.swap_en = 1'b1;
      bus.dst     = 4'd3;
      bus.wdata   = 36'hFEDCBA987;
      bus.swap_a  = 4'd0;
      bus.swap_b  = 4'd1;
      bus.src     = {4'd3, 4'd1};
      push(cyc, 0, 36'h023456781, "wrswap_p0_e1");
      push(cyc, 1, BYP ? 36'hFEDCBA987 : 36'h0, "wrswap_same_cycle");
      push(cyc + 1, 3, 36'd1, "wrswap_err_set");
      push(cyc + 2, 3, 36'd0, "wrswap_err_clear");
      step();
      idle();
      bus.src = {4'd3, 4'd0};
      push(cyc, 1, 36'hFEDCBA987, "wrswap_result");
      model[3] = 36'hFEDCBA987;

      // Swap with an out-of-range tile index on either side.
      step();
      idle();
      bus.swap_en = 1'b1;
      bus.dst     = 4'd1;
      bus.swap_a  = 4'd9;
      bus.swap_b  = 4'd2;
      bus.src     = {4'd0, 4'd1};
      push(cyc, 0, 36'h023456781, "badidx_a_keep");
      push(cyc + 1, 3, 36'd1, "badidx_a_err");
      step();
      idle();
      bus.swap_en = 1'b1;
      bus.dst     = 4'd1;
      bus.swap_a  = 4'd2;
      bus.swap_b  = 4'd15;
      bus.src     = {4'd0, 4'd1};
      push(cyc, 0, 36'h023456781, "badidx_b_keep");
      push(cyc + 1, 3, 36'd1, "badidx_b_err");
      step();
      idle();
      push(cyc + 1, 3, 36'd0, "badidx_err_clear");
      read_all("run");

      // Reset, then reset again five cycles into the sweep.
      step();
      idle();
      rst_n = 1'b0;
      push(cyc + 1, 3, 36'd0, "rst2_err");
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) step();
         push(cyc, 2, 36'd0, $sformatf("partial_ready%0d", i));
      end
      step();
      rst_n = 1'b0;
      push(cyc, 2, 36'd0, "midrst_ready0");
      step();
      push(cyc, 2, 36'd0, "midrst_ready1");
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (i > 0) step();
         push(cyc, 2, 36'd0, $sformatf("resweep_ready%0d", i));
      end
      step();
      push(cyc, 2, 36'd1, "resweep_ready_high");
      model_init();
      read_all("reinit");

      step();
      step();
      if (sbq.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard_drain: %0d expectations left, required 0", sbq.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
